// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII transmit framer.
package ether_pkg;

  // Framer states, in transmit order
  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    IFG
  } state_t;

  // Dibit repeated throughout the preamble (0x55 sent LSB pair first)
  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;

  // Start-of-frame delimiter, serialised through the same shifter as payload
  localparam logic [7:0] SFD_BYTE = 8'hD5;

endpackage

// File: rtl/ether_tx_byte_to_dibit.sv
// Byte-to-dibit serialiser: holds one byte and presents it two bits at a time,
// least significant pair first. done flags the fourth (final) dibit.
module byte_to_dibit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       shift,
  output logic [1:0] dibit,
  output logic       done
);

  logic [7:0] sr;
  logic [1:0] idx;

  // Load restarts the byte at dibit 0; shift moves to the next pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= 8'h00;
      idx <= 2'd0;
    end else if (load) begin
      sr  <= data;
      idx <= 2'd0;
    end else if (shift) begin
      sr  <= {2'b00, sr[7:2]};
      idx <= idx + 2'd1;
    end
  end

  assign dibit = sr[1:0];
  assign done  = (idx == 2'd3);

endmodule

// File: rtl/ether_tx.sv
// RMII transmit framer: preamble + SFD, payload serialisation from a one-byte
// hold register, underrun abort and inter-frame gap enforcement.
module ether_tx
  import ether_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_CYCLES     = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  input  logic       axiil,
  output logic       axiir,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       underrun
);

  // The IDLE cycle that accepts the next frame's first byte completes the gap,
  // so IFG itself lasts one cycle less than the full gap.
  localparam logic [5:0] PRE_LAST = 6'(4 * PREAMBLE_BYTES - 1);
  localparam logic [5:0] IFG_LAST = 6'(IFG_CYCLES - 2);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic [7:0] hold_data;
  logic       hold_last;
  logic       hold_valid;
  logic       cur_last;
  logic       last_taken;
  logic       alive;

  logic       sh_load, sh_shift, sh_done;
  logic [7:0] sh_data;
  logic [1:0] sh_dibit;

  logic       drain;
  logic       abort;
  logic       ready_c;
  logic       tx_en;
  logic [1:0] tx_d;
  logic       accept;

  byte_to_dibit u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sh_load),
    .data  (sh_data),
    .shift (sh_shift),
    .dibit (sh_dibit),
    .done  (sh_done)
  );

  assign axiir  = alive && ready_c;
  assign accept = axiiv && axiir;

  // State and shared preamble/IFG counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, shifter control, hold drain and pin values for the next edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_data  = hold_data;
    drain    = 1'b0;
    abort    = 1'b0;
    ready_c  = 1'b0;
    tx_en    = 1'b0;
    tx_d     = 2'b00;
    unique case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (accept) begin
          state_d = PREAMBLE;
          cnt_d   = 6'd0;
        end
      end
      PREAMBLE: begin
        tx_en   = 1'b1;
        tx_d    = PREAMBLE_DIBIT;
        ready_c = !hold_valid && !last_taken;
        if (cnt_q == PRE_LAST) begin
          state_d = SFD;
          cnt_d   = 6'd0;
          sh_load = 1'b1;
          sh_data = SFD_BYTE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      SFD: begin
        tx_en    = 1'b1;
        tx_d     = sh_dibit;
        sh_shift = 1'b1;
        if (sh_done) begin
          drain   = 1'b1;
          sh_load = 1'b1;
          state_d = DATA;
        end
        ready_c = (!hold_valid || drain) && !last_taken;
      end
      DATA: begin
        tx_en    = 1'b1;
        tx_d     = sh_dibit;
        sh_shift = 1'b1;
        if (sh_done) begin
          if (cur_last) begin
            state_d = IFG;
            cnt_d   = 6'd0;
          end else if (hold_valid) begin
            drain   = 1'b1;
            sh_load = 1'b1;
          end else begin
            abort   = 1'b1;
            state_d = IFG;
            cnt_d   = 6'd0;
          end
        end
        ready_c = (!hold_valid || drain) && !last_taken && !abort;
      end
      IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // Hold register: refilled on accept, emptied when its byte moves to the shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= 8'h00;
      hold_last  <= 1'b0;
      hold_valid <= 1'b0;
      cur_last   <= 1'b0;
    end else begin
      if (accept) begin
        hold_data  <= axiid;
        hold_last  <= axiil;
        hold_valid <= 1'b1;
      end else if (drain) begin
        hold_valid <= 1'b0;
      end
      if (drain) begin
        cur_last <= hold_last;
      end
    end
  end

  // Remembers that the frame's last byte is in, so no more bytes join this frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_taken <= 1'b0;
    end else if (accept) begin
      last_taken <= axiil;
    end else if (state_q == IFG) begin
      last_taken <= 1'b0;
    end
  end

  // Keeps ready low while reset is held, then high from the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // Registered RMII pins and the underrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axiov    <= 1'b0;
      axiod    <= 2'b00;
      underrun <= 1'b0;
    end else begin
      axiov    <= tx_en;
      axiod    <= tx_d;
      underrun <= abort;
    end
  end

endmodule

// File: tb/tb_ether_tx.sv
// Self-checking bench for the RMII transmit framer: table of directed frames
// plus hand-written reset, underrun and back-to-back sequences.
module tb_ether_tx;

  logic       clk;
  logic       rst_n;
  logic       axiiv;
  logic [7:0] axiid;
  logic       axiil;
  logic       axiir;
  logic       axiov;
  logic [1:0] axiod;
  logic       underrun;

  int n_checks;
  int n_errors;

  ether_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .axiiv    (axiiv),
    .axiid    (axiid),
    .axiil    (axiil),
    .axiir    (axiir),
    .axiov    (axiov),
    .axiod    (axiod),
    .underrun (underrun)
  );

  // 50 MHz reference clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Frame vector: bytes packed with byte 0 in bits [7:0]; expected payload
  // dibits in wire order, first dibit in bits [31:30]
  typedef struct {
    string       name;
    int          n;
    logic [31:0] bytes;
    logic [31:0] exp_stream;
    int          exp_len;
    int          pre_stall;
    int          mid_stall;
  } vec_t;

  vec_t vecs[7];

  // Monitor state (written only by the monitor process)
  logic [1:0] cap[$];
  int         lens[$];
  int         gaps[$];
  int         fstart[$];
  int         on_run, off_run, und_cnt, od_bad;
  bit         prev_ov, seen_frame;
  bit         mon_clear;

  // Bytes the DUT accepted, in order
  logic [7:0] sb[$];

  // Monitor: captures TXD while TXEN is high, frame lengths, gaps and underruns
  always @(negedge clk) begin
    if (mon_clear) begin
      cap.delete(); lens.delete(); gaps.delete(); fstart.delete();
      on_run = 0; off_run = 0; und_cnt = 0; od_bad = 0;
      prev_ov = 1'b0; seen_frame = 1'b0;
    end else begin
      if (axiov) begin
        if (!prev_ov) begin
          if (seen_frame) gaps.push_back(off_run);
          fstart.push_back(cap.size());
          on_run = 0;
        end
        cap.push_back(axiod);
        on_run++;
      end else begin
        if (prev_ov) begin
          lens.push_back(on_run);
          seen_frame = 1'b1;
          off_run = 0;
        end
        off_run++;
        if (axiod != 2'b00) od_bad++;
      end
      if (underrun) und_cnt++;
      prev_ov = axiov;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    #1 mon_clear = 1'b1;
    sb.delete();
    @(negedge clk);
    #1 mon_clear = 1'b0;
  endtask

  // Presents one byte from a negedge and returns at the negedge after it transfers
  task automatic send_byte(input logic [7:0] b, input logic last);
    int t;
    axiiv = 1'b1;
    axiid = b;
    axiil = last;
    t = 0;
    while (!axiir && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("ready_timeout", 32'(axiir), 32'd1);
    else sb.push_back(b);
    @(negedge clk);
  endtask

  task automatic junk_cycles(input int n);
    axiiv = 1'b0;
    for (int i = 0; i < n; i++) begin
      axiid = 8'($urandom);
      axiil = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    axiiv = 1'b0;
    axiil = 1'b0;
    axiid = 8'h00;
  endtask

  task automatic wait_frames(input string name, input int k);
    int t;
    t = 0;
    while (lens.size() < k && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check(name, 32'(lens.size()), 32'(k));
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (!axiir && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check(name, 32'(axiir), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] bb;
    bb = v.bytes;
    junk_cycles(v.pre_stall);
    for (int i = 0; i < v.n; i++) begin
      send_byte(bb[8*i +: 8], (i == v.n - 1));
      if (i == 0 && v.mid_stall > 0) junk_cycles(v.mid_stall);
    end
    idle_inputs();
  endtask

  // Checks frame fi of the capture: length, preamble, SFD, payload and scoreboard
  task automatic checkOutput(input string name, input int fi, input int n,
                             input logic [31:0] exp_stream, input int exp_len,
                             input int sb_base);
    int          base, bad;
    logic [7:0]  sfd;
    logic [31:0] got;
    logic [7:0]  dec;
    if (lens.size() <= fi || fstart.size() <= fi || sb.size() < sb_base + n) begin
      check({name, "_frame_missing"}, 32'(lens.size()), 32'(fi + 1));
      return;
    end
    check({name, "_txen_len"}, 32'(lens[fi]), 32'(exp_len));
    base = fstart[fi];
    if (cap.size() < base + 32 + 4 * n) begin
      check({name, "_capture_short"}, 32'(cap.size()), 32'(base + 32 + 4 * n));
      return;
    end
    bad = 0;
    for (int i = 0; i < 28; i++) if (cap[base + i] != 2'b01) bad++;
    check({name, "_preamble_bad_dibits"}, 32'(bad), 32'd0);
    sfd = {cap[base + 28], cap[base + 29], cap[base + 30], cap[base + 31]};
    check({name, "_sfd"}, {24'd0, sfd}, 32'h57);
    got = 32'd0;
    for (int i = 0; i < 4 * n; i++) got[31 - 2 * i -: 2] = cap[base + 32 + i];
    check({name, "_payload"}, got, exp_stream);
    bad = 0;
    for (int j = 0; j < n; j++) begin
      dec = {cap[base + 35 + 4 * j], cap[base + 34 + 4 * j],
             cap[base + 33 + 4 * j], cap[base + 32 + 4 * j]};
      if (dec != sb[sb_base + j]) bad++;
    end
    check({name, "_scoreboard"}, 32'(bad), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    mon_clear = 1'b0;
    rst_n     = 1'b0;
    idle_inputs();

    vecs[0] = '{"single_a5",   1, 32'h0000_00A5, 32'h5A00_0000, 36, 0, 0};
    vecs[1] = '{"three_byte",  3, 32'h00FF_0201, 32'h4080_FF00, 44, 0, 0};
    vecs[2] = '{"two_byte",    2, 32'h0000_3412, 32'h841C_0000, 40, 0, 0};
    vecs[3] = '{"four_byte",   4, 32'hEFBE_ADDE, 32'hB77A_BEFB, 48, 0, 0};
    vecs[4] = '{"single_80",   1, 32'h0000_0080, 32'h0200_0000, 36, 0, 0};
    vecs[5] = '{"a5_stalled",  1, 32'h0000_00A5, 32'h5A00_0000, 36,
                int'($urandom_range(3, 12)), 0};
    vecs[6] = '{"three_stall", 3, 32'h00FF_0201, 32'h4080_FF00, 44,
                0, int'($urandom_range(1, 20))};

    // Reset state while held
    repeat (3) @(negedge clk);
    check("rst_axiov", 32'(axiov), 32'd0);
    check("rst_axiod", 32'(axiod), 32'd0);
    check("rst_axiir", 32'(axiir), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_axiir", 32'(axiir), 32'd1);
    check("post_rst_axiov", 32'(axiov), 32'd0);

    // Directed frames from the table
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      applyStimulus(vecs[v]);
      wait_frames({vecs[v].name, "_timeout"}, 1);
      wait_idle({vecs[v].name, "_idle_timeout"});
      checkOutput(vecs[v].name, 0, vecs[v].n, vecs[v].exp_stream, vecs[v].exp_len, 0);
      check({vecs[v].name, "_underruns"}, 32'(und_cnt), 32'd0);
      check({vecs[v].name, "_txd_while_idle"}, 32'(od_bad), 32'd0);
    end

    // Underrun: byte 0x55 (not last) then a long stall; late byte 0x3C waits out the gap
    clear_mon();
    send_byte(8'h55, 1'b0);
    junk_cycles(40);
    send_byte(8'h3C, 1'b1);
    idle_inputs();
    wait_frames("underrun_timeout", 2);
    wait_idle("underrun_idle_timeout");
    check("underrun_pulses", 32'(und_cnt), 32'd1);
    checkOutput("underrun_f0", 0, 1, 32'h5500_0000, 36, 0);
    checkOutput("underrun_f1", 1, 1, 32'h3C00_0000, 36, 1);
    if (gaps.size() > 0) check("underrun_gap", 32'(gaps[0]), 32'd48);
    else check("underrun_gap_missing", 32'(gaps.size()), 32'd1);

    // Back-to-back frames: second frame offered the cycle after the last accept
    clear_mon();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b1);
    idle_inputs();
    wait_frames("b2b_timeout", 2);
    wait_idle("b2b_idle_timeout");
    checkOutput("b2b_f0", 0, 2, 32'h841C_0000, 40, 0);
    checkOutput("b2b_f1", 1, 2, 32'hB77A_0000, 40, 2);
    if (gaps.size() > 0) check("b2b_gap", 32'(gaps[0]), 32'd48);
    else check("b2b_gap_missing", 32'(gaps.size()), 32'd1);
    check("b2b_underruns", 32'(und_cnt), 32'd0);

    // Reset in the middle of the payload drops the pins immediately
    clear_mon();
    send_byte(8'hC3, 1'b0);
    idle_inputs();
    repeat (33) @(negedge clk);
    check("midrst_in_data", 32'(axiov), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_axiov", 32'(axiov), 32'd0);
    check("midrst_axiod", 32'(axiod), 32'd0);
    check("midrst_axiir", 32'(axiir), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_post_axiir", 32'(axiir), 32'd1);
    check("midrst_post_axiov", 32'(axiov), 32'd0);

    // Framer restarts cleanly after the abort-by-reset
    clear_mon();
    applyStimulus(vecs[0]);
    wait_frames("after_rst_timeout", 1);
    wait_idle("after_rst_idle_timeout");
    checkOutput("after_rst", 0, 1, 32'h5A00_0000, 36, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
